// File: rtl/alu_op_issuer.sv
// alu_op_issuer: drives operand/select requests onto a combinational ALU, waits
// a fixed settle time, then queues {sel, result} in a show-ahead FIFO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/ready/a/b/sel : request handshake and operands
//   alu_a/alu_b/alu_sel   : registered operands held on the ALU
//   alu_out               : combinational ALU result, sampled after settling
//   res_valid/ready/data  : result FIFO head, {sel, result}
//   op_count              : completed captures, modulo 256
module alu_op_issuer #(
  parameter int WIDTH      = 5,
  parameter int SETTLE_CYC = 2,
  parameter int DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [1:0]         req_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH+1:0]   res_data,
  output logic [7:0]         op_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [1:0]       r_sel;
  logic [7:0]       r_ops;
  logic [WIDTH+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_occ;
  logic             w_acc, w_push, w_pop;
  assign req_ready = (r_state == IDLE) && (r_occ != (AW+1)'(DEPTH));
  assign w_acc     = req_valid && req_ready;
  // capture on the last settle edge; counter still holds 1 here
  assign w_push    = (r_state == SETTLE) && (r_cnt == 4'd1);
  assign w_pop     = res_valid && res_ready;
  assign res_valid = r_occ != '0;
  // empty FIFO reads as zero so reset shows a clean head
  assign res_data  = res_valid ? r_mem[r_rp] : '0;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign op_count  = r_ops;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_ops   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_occ   <= '0;
    end else begin
      if (w_acc) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_sel   <= req_sel;
        r_cnt   <= 4'(SETTLE_CYC);
        r_state <= SETTLE;
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_push) begin
          r_state <= IDLE;
          r_ops   <= r_ops + 8'd1;
        end
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_occ <= r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {r_sel, alu_out};
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: randomized and directed checks of alu_op_issuer against a queue-based model.
module tb_alu_op_issuer;
  localparam int W = 5, SC = 2, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, res_valid, res_ready = 0;
  logic [W-1:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_out;
  logic [1:0] req_sel = 0, alu_sel;
  logic [W+1:0] res_data;
  logic [7:0] op_count;
  int checks = 0, errors = 0, cyc = 0;
  logic [W+1:0] m_q[$];
  logic [W+1:0] m_pend;
  logic [W-1:0] m_a, m_b;
  logic [1:0] m_s;
  logic [1:0] dut_tags[$];
  int cap_cyc[$];
  int m_left, m_ops, m_accn;
  bit m_busy, m_acc;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] s);
    return s == 0 ? a + b : s == 1 ? a - b : s == 2 ? a & b : a | b;
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);
  always #5 clk = ~clk;

  alu_op_issuer #(.WIDTH(W), .SETTLE_CYC(SC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .op_count(op_count));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_busy = 0; m_left = 0; m_ops = 0; m_accn = 0; m_acc = 0;
    m_a = 0; m_b = 0; m_s = 0;
  endtask

  task automatic step();
    bit rdy, pop, cap, acc;
    logic [W-1:0] a, b;
    logic [1:0] s;
    logic [7:0] prev;
    rdy = !m_busy && (m_q.size() < DEPTH);
    chk("req_ready", req_ready, rdy);
    pop = (m_q.size() != 0) && res_ready;
    cap = m_busy && m_left == 1;
    acc = rdy && req_valid;
    a = req_a; b = req_b; s = req_sel;
    if (res_valid && res_ready) dut_tags.push_back(res_data[W+1:W]);
    prev = op_count;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      m_q.push_back(m_pend);
      m_ops++;
      m_busy = 0;
    end else if (m_busy) m_left--;
    m_acc = acc;
    if (acc) begin
      m_busy = 1; m_left = SC; m_accn++;
      m_a = a; m_b = b; m_s = s;
      m_pend = {s, alu_fn(a, b, s)};
    end
    #1;
    if (op_count !== prev) cap_cyc.push_back(cyc);
    chk("res_valid", res_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("res_data", res_data, m_q[0]);
    chk("op_count", op_count, m_ops % 256);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_s);
    cyc++;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] s);
    int n = 0;
    req_a = a; req_b = b; req_sel = s; req_valid = 1;
    do begin step(); n++; end while (!m_acc && n < 50);
    if (!m_acc) begin
      checks++; errors++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
  endtask

  task automatic rand_ops();
    req_a = W'($urandom); req_b = W'($urandom); req_sel = 2'($urandom);
  endtask

  initial begin
    logic [W-1:0] a5;
    int n;
    m_reset();
    #3;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk); rst_n = 1;
    // single op with latency measurement
    send(5'b00010, 5'b11100, 2'b00);
    req_valid = 0;
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    chk("single_latency", n, SC);
    chk("single_data", res_data, 7'b00_11110);
    chk("single_count", op_count, 1);
    // back-to-back with res_ready high
    res_ready = 1;
    repeat (2) step();
    dut_tags.delete(); cap_cyc.delete();
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 2'(i));
    req_valid = 0;
    repeat (6) step();
    chk("b2b_ntags", dut_tags.size(), 4);
    for (int i = 0; i < 4 && i < dut_tags.size(); i++) chk("b2b_tag", dut_tags[i], i);
    chk("b2b_ncap", cap_cyc.size(), 4);
    for (int i = 1; i < cap_cyc.size(); i++) chk("b2b_spacing", cap_cyc[i] - cap_cyc[i-1], SC + 1);
    // fill the FIFO, 5th request must wait for a pop
    res_ready = 0;
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 2'($urandom));
    a5 = W'($urandom);
    req_a = a5; req_b = W'($urandom); req_sel = 2'($urandom);
    repeat (6) step();
    chk("full_ready", req_ready, 0);
    chk("full_valid", res_valid, 1);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("pop_ready", req_ready, 1);
    step();
    chk("fifth_acc_a", alu_a, a5);
    req_valid = 0; res_ready = 1;
    repeat (12) step();
    // capture and pop on the same edge with two queued
    res_ready = 0;
    send(W'($urandom), W'($urandom), 2'd1);
    send(W'($urandom), W'($urandom), 2'd2);
    send(W'($urandom), W'($urandom), 2'd3);
    req_valid = 0;
    while (m_left != 1 && cyc < 5000) step();
    res_ready = 1;
    step();
    res_ready = 0;
    chk("simul_valid", res_valid, 1);
    chk("simul_head_tag", res_data[W+1:W], 2'd2);
    res_ready = 1;
    repeat (6) step();
    // random traffic over many pointer wraps
    repeat (120) begin
      req_valid = 1'($urandom); res_ready = 1'($urandom); rand_ops();
      step();
    end
    // reset one cycle into SETTLE with two results queued
    req_valid = 0; res_ready = 1;
    repeat (8) step();
    res_ready = 0;
    send(W'($urandom), W'($urandom), 2'd0);
    send(W'($urandom), W'($urandom), 2'd1);
    send(W'($urandom), W'($urandom), 2'd2);
    req_valid = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_alu_sel", alu_sel, 0);
    chk("mid_res_valid", res_valid, 0);
    chk("mid_res_data", res_data, 0);
    chk("mid_op_count", op_count, 0);
    m_reset();
    @(negedge clk); rst_n = 1;
    repeat (5) step();
    // op_count wrap after 257 captures
    res_ready = 1;
    n = 0;
    while (m_ops < 257 && n < 3000) begin
      req_valid = m_accn < 257;
      rand_ops();
      step();
      n++;
    end
    req_valid = 0;
    repeat (3) step();
    chk("wrap_count", op_count, 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
